// File: rtl/fifo_if_pkg.sv
// Shared types and constants for the FIFO read-side stream master.
// Optional statistics are enabled with the FIFO_READER_STATS_EN macro (see fifo_stream_reader).
package fifo_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_e;

  localparam string MODE_TRUE  = "TRUE";
  localparam string MODE_FALSE = "FALSE";
  localparam int    SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order skid buffer; the head entry drives the registered output word.
module fifo_rd_skid_buf
  import fifo_if_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  logic [1:0]        occ_reg, occ_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic [DATA_W-1:0] tail_reg, tail_next;
  logic              valid_reg;

  always_comb begin
    occ_next  = occ_reg;
    head_next = head_reg;
    tail_next = tail_reg;
    unique case ({push, pop})
      2'b10: begin
        if (occ_reg == 2'd0) head_next = push_data;
        else                 tail_next = push_data;
        occ_next = occ_reg + 2'd1;
      end
      2'b01: begin
        head_next = tail_reg;
        occ_next  = occ_reg - 2'd1;
      end
      2'b11: begin
        // Full buffer: shift the tail forward and refill it, occupancy unchanged.
        if (occ_reg == 2'(SKID_DEPTH)) begin
          head_next = tail_reg;
          tail_next = push_data;
        end else begin
          head_next = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      occ_reg   <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      occ_reg   <= occ_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      valid_reg <= (occ_next != 2'd0);
    end
  end

  assign occ        = occ_reg;
  assign head_valid = valid_reg;
  assign head_data  = head_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a single-clock FIFO (FWFT or registered read) onto a valid/ready stream.
// Define FIFO_READER_STATS_EN to add the words_out accepted-word counter.
module fifo_stream_reader
  import fifo_if_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter string FWFT_MODE = "TRUE",
  parameter int    CNT_W     = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              f_empty,
  input  logic              f_fail,
  input  logic [DATA_W-1:0] f_r_data,
  output logic              f_r_req,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
`ifdef FIFO_READER_STATS_EN
  output logic [CNT_W-1:0]  words_out,
`endif
  output logic              err
);

  localparam bit IS_FWFT = (FWFT_MODE == MODE_TRUE);

  rd_state_e  state_reg, state_next;
  logic       inflight_reg, inflight_next;
  logic       err_reg;
  logic       pop_out;
  logic       push;
  logic [1:0] occ;
  logic [1:0] pending;

  assign pop_out = m_valid & m_ready;
  assign pending = occ + {1'b0, inflight_reg} - {1'b0, pop_out};
  assign f_r_req = nrst & en & ~f_empty & (state_reg == RUN) & (pending < 2'(SKID_DEPTH));

  generate
    if (IS_FWFT) begin : g_fwft
      assign push          = f_r_req;
      assign inflight_next = 1'b0;
    end else begin : g_registered
      // The word requested last cycle is on f_r_data now.
      assign push          = inflight_reg;
      assign inflight_next = f_r_req;
    end
  endgenerate

  fifo_rd_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_data (f_r_data),
    .pop       (pop_out),
    .occ       (occ),
    .head_valid(m_valid),
    .head_data (m_data)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = ((occ != 2'd0) || inflight_reg) ? DRAIN : IDLE;
      DRAIN: begin
        if (en)                                     state_next = RUN;
        else if ((occ == 2'd0) && !inflight_reg)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      inflight_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_reg | f_fail;
    end
  end

  assign busy = (state_reg != IDLE);
  assign err  = err_reg;

`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0] words_out_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        words_out_reg <= '0;
    else if (pop_out) words_out_reg <= words_out_reg + 1'b1;
  end

  assign words_out = words_out_reg;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: instance 0 runs FWFT mode, instance 1 registered mode, each fed by a FIFO model.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  en, f_empty, f_fail, f_r_req, m_valid, m_ready, busy, err;
  logic [31:0] f_r_data [2];
  logic [31:0] m_data   [2];
`ifdef FIFO_READER_STATS_EN
  logic [15:0] words_out [2];
`endif

  logic [31:0] mem [2][64];
  int          rptr [2] = '{0, 0};
  int          wptr [2] = '{0, 0};
  logic [31:0] rd_reg1 = '0;
  logic [31:0] exp_q [2][$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cnt [2] = '{0, 0};
  int pop_cnt [2] = '{0, 0};
  int req_rise [2] = '{0, 0};
  int v_rise [2] = '{0, 0};
  int last_req [2] = '{0, 0};
  int last_v [2] = '{0, 0};
  int bad_req = 0;
  logic [1:0] prev_req = '0;
  logic [1:0] prev_v = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_stream_reader #(.DATA_W(32), .FWFT_MODE("TRUE"), .CNT_W(16)) u_fwft (
    .clk(clk), .nrst(nrst), .en(en[0]), .f_empty(f_empty[0]), .f_fail(f_fail[0]),
    .f_r_data(f_r_data[0]), .f_r_req(f_r_req[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_data(m_data[0]), .busy(busy[0]),
`ifdef FIFO_READER_STATS_EN
    .words_out(words_out[0]),
`endif
    .err(err[0])
  );

  fifo_stream_reader #(.DATA_W(32), .FWFT_MODE("FALSE"), .CNT_W(16)) u_regd (
    .clk(clk), .nrst(nrst), .en(en[1]), .f_empty(f_empty[1]), .f_fail(f_fail[1]),
    .f_r_data(f_r_data[1]), .f_r_req(f_r_req[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_data(m_data[1]), .busy(busy[1]),
`ifdef FIFO_READER_STATS_EN
    .words_out(words_out[1]),
`endif
    .err(err[1])
  );

  // FIFO models: FWFT shows the head, registered mode returns it one edge after r_req
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_empty
      assign f_empty[gi] = (rptr[gi] == wptr[gi]);
    end
  endgenerate
  assign f_r_data[0] = mem[0][rptr[0]];
  assign f_r_data[1] = rd_reg1;

  always @(posedge clk) begin
    if (f_r_req[0]) rptr[0] <= rptr[0] + 1;
    if (f_r_req[1]) begin
      rptr[1] <= rptr[1] + 1;
      rd_reg1 <= mem[1][rptr[1]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] w, input bit expect_out);
    mem[i][wptr[i]] = w;
    wptr[i]++;
    if (expect_out) exp_q[i].push_back(w);
  endtask

  // Monitor: timing bookkeeping and scoreboard compare on every accepted word
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (f_r_req[i]) begin
        req_cnt[i]++;
        last_req[i] = cyc;
        if (!prev_req[i]) req_rise[i] = cyc;
        if (f_empty[i]) bad_req++;
      end
      prev_req[i] = f_r_req[i];
      if (m_valid[i] && !prev_v[i]) v_rise[i] = cyc;
      prev_v[i] = m_valid[i];
      if (m_valid[i] && m_ready[i]) begin
        pop_cnt[i]++;
        last_v[i] = cyc;
        $display("inst%0d word %08h cycle %0d", i, m_data[i], cyc);
        if (exp_q[i].size() == 0) check($sformatf("unexpected_word%0d", i), m_data[i], 64'hdead);
        else check($sformatf("data%0d", i), m_data[i], exp_q[i].pop_front());
      end
    end
  end

  initial begin
    int r0 [2];
    int p0 [2];
    bit found;
    nrst = 1'b0; en = '0; m_ready = '0; f_fail = '0;
    #3;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_valid%0d", i), m_valid[i], 0);
      check($sformatf("rst_req%0d", i), f_r_req[i], 0);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      check($sformatf("rst_err%0d", i), err[i], 0);
      check($sformatf("rst_data%0d", i), m_data[i], 0);
    end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Streaming at full rate: A0..A3
    for (int i = 0; i < 2; i++) begin
      r0[i] = req_cnt[i]; p0[i] = pop_cnt[i];
      for (int j = 0; j < 4; j++) preload(i, 32'hA0 + j, 1'b1);
    end
    m_ready = 2'b11; en = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stream_reqs%0d", i), req_cnt[i] - r0[i], 4);
      check($sformatf("stream_req_run%0d", i), last_req[i] - req_rise[i], 3);
      check($sformatf("stream_latency%0d", i), v_rise[i] - req_rise[i], i + 1);
      check($sformatf("stream_pops%0d", i), pop_cnt[i] - p0[i], 4);
      check($sformatf("stream_no_gap%0d", i), last_v[i] - v_rise[i], 3);
      check($sformatf("stream_req_empty%0d", i), f_r_req[i], 0);
      check($sformatf("stream_busy%0d", i), busy[i], 1);
`ifdef FIFO_READER_STATS_EN
      check($sformatf("words_out%0d", i), words_out[i], 4);
`endif
    end
    en = '0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: five words, consumer stalled
    m_ready = '0;
    for (int i = 0; i < 2; i++) begin
      r0[i] = req_cnt[i]; p0[i] = pop_cnt[i];
      for (int j = 0; j < 5; j++) preload(i, 32'hB0 + j, 1'b1);
    end
    en = 2'b11;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_reqs%0d", i), req_cnt[i] - r0[i], 2);
      check($sformatf("bp_valid%0d", i), m_valid[i], 1);
      check($sformatf("bp_hold_a%0d", i), m_data[i], 32'hB0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("bp_hold_b%0d", i), m_data[i], 32'hB0);
    m_ready = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_total_reqs%0d", i), req_cnt[i] - r0[i], 5);
      check($sformatf("bp_total_pops%0d", i), pop_cnt[i] - p0[i], 5);
    end
    en = '0;
    repeat (3) @(posedge clk);
    #1;

    // Drain, registered instance: en drops the cycle after the first request
    r0[1] = req_cnt[1]; p0[1] = pop_cnt[1];
    preload(1, 32'hC0, 1'b1);
    preload(1, 32'hC1, 1'b0);
    preload(1, 32'hC2, 1'b0);
    en[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (f_r_req[1]) found = 1'b1;
    end
    check("drain_req_seen", found, 1);
    @(posedge clk);
    #1 en[1] = 1'b0;
    @(negedge clk);
    check("drain_busy", busy[1], 1);
    repeat (8) @(posedge clk);
    #1;
    check("drain_reqs", req_cnt[1] - r0[1], 1);
    check("drain_pops", pop_cnt[1] - p0[1], 1);
    check("drain_left", wptr[1] - rptr[1], 2);
    check("drain_idle", busy[1], 0);
    wptr[1] = rptr[1];

    // Sticky error
    f_fail = 2'b11;
    @(posedge clk);
    #1 f_fail = '0;
    for (int i = 0; i < 2; i++) check($sformatf("err_set%0d", i), err[i], 1);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("err_sticky%0d", i), err[i], 1);

    // Reset mid-stream with a full skid buffer
    m_ready = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) preload(i, 32'hE0 + j, 1'b1);
    en = 2'b11;
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("pre_rst_valid%0d", i), m_valid[i], 1);
    #2 nrst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("arst_valid%0d", i), m_valid[i], 0);
      check($sformatf("arst_req%0d", i), f_r_req[i], 0);
      check($sformatf("arst_busy%0d", i), busy[i], 0);
      check($sformatf("arst_err%0d", i), err[i], 0);
      exp_q[i].delete();
      wptr[i] = rptr[i];
    end
    en = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p0[i] = pop_cnt[i];
      preload(i, 32'hF0, 1'b1);
      preload(i, 32'hF1, 1'b1);
    end
    m_ready = 2'b11; en = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("restart_pops%0d", i), pop_cnt[i] - p0[i], 2);
      check($sformatf("scoreboard_empty%0d", i), exp_q[i].size(), 0);
    end
    check("no_req_when_empty", bad_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
